arb8_sched: RTL and testbench



---
 rtl/arb8_sched.sv | 57 +++++
 tb/tb_arb8_sched.sv | 132 +++++++++++++
 2 files changed

// File: rtl/arb8_sched.sv
// arb8_sched: eight-way fixed-priority/round-robin arbiter with hold-limit preemption
module arb8_sched #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       rr_en,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_valid
);
    typedef enum logic {IDLE, GRANT} state_t;
    localparam logic [7:0] LAST = 8'(MAX_HOLD == 0 ? 0 : MAX_HOLD - 1);
    state_t     state, state_n;
    logic [7:0] cnt, cnt_n, cand, rot, gnt_n;
    logic [2:0] ptr, ptr_n, base, off, win, id_n;
    logic       rel, pre, hand, take, valid_n;
    always_comb begin
        cand = state == GRANT ? req & ~(8'd1 << gnt_id) : req;
        base = rr_en ? ptr : 3'd0;
        rot  = 8'({cand, cand} >> base);
        off  = '0;
        for (int i = 7; i >= 0; i--)
            if (rot[i]) off = 3'(i);
        win = base + off;
    end
    always_comb begin
        rel     = !req[gnt_id];
        pre     = MAX_HOLD != 0 && cnt == LAST && |cand;
        hand    = state == IDLE || rel || pre;
        take    = hand && |cand;
        state_n = hand ? (take ? GRANT : IDLE) : GRANT;
        id_n    = take ? win : (hand ? 3'd0 : gnt_id);
        valid_n = state_n == GRANT;
        gnt_n   = valid_n ? 8'd1 << id_n : 8'd0;
        ptr_n   = take ? win + 3'd1 : ptr;
        cnt_n   = hand ? 8'd0 : (cnt == LAST ? cnt : cnt + 8'd1);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            ptr       <= '0;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            ptr       <= ptr_n;
            gnt       <= gnt_n;
            gnt_id    <= id_n;
            gnt_valid <= valid_n;
        end
    end
endmodule

// File: tb/tb_arb8_sched.sv
// tb_arb8_sched: directed checks of arb8_sched with unlimited hold and hold limit 4
module tb_arb8_sched;
    logic       clk = 0, rst = 1, rr_en = 0;
    logic [7:0] req = 8'hFF;
    logic [7:0] gnt0, gnt4;
    logic [2:0] id0, id4;
    logic       v0, v4;
    int         checks = 0, failures = 0;

    always #5 clk = ~clk;

    arb8_sched #(.MAX_HOLD(0)) u_nohold (.clk(clk), .rst(rst), .req(req), .rr_en(rr_en),
                                         .gnt(gnt0), .gnt_id(id0), .gnt_valid(v0));
    arb8_sched #(.MAX_HOLD(4)) u_hold (.clk(clk), .rst(rst), .req(req), .rr_en(rr_en),
                                       .gnt(gnt4), .gnt_id(id4), .gnt_valid(v4));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        chk("inv0", {24'd0, gnt0}, v0 ? 32'd1 << id0 : 32'd0);
        chk("inv4", {24'd0, gnt4}, v4 ? 32'd1 << id4 : 32'd0);
        chk("inv4_idle_id", {29'd0, id4}, v4 ? {29'd0, id4} : 32'd0);
    end

    initial begin
        step();
        step();
        chk("rst_gnt", gnt4, 0);
        chk("rst_valid", v4, 0);
        chk("rst_id", id4, 0);
        chk("rst_gnt0", gnt0, 0);
        rst = 0;
        step();
        chk("first_gnt", gnt4, 8'h01);
        chk("first_id", id4, 0);
        chk("first_gnt0", gnt0, 8'h01);
        req = 8'h00;
        step();
        chk("drop_valid", v0, 0);
        // fixed priority handover without idle bubble
        req = 8'hA4;
        step();
        chk("fp_gnt2", gnt0, 8'h04);
        chk("fp_id2", id0, 2);
        req = 8'hA0;
        step();
        chk("fp_gnt5", gnt0, 8'h20);
        chk("fp_id5", id0, 5);
        chk("fp_valid5", v0, 1);
        req = 8'h80;
        step();
        chk("fp_gnt7", gnt0, 8'h80);
        req = 8'h00;
        step();
        chk("fp_gnt_end", gnt0, 0);
        chk("fp_valid_end", v0, 0);
        chk("fp_id_end", id0, 0);
        // round robin with hold limit 4
        rr_en = 1;
        req   = 8'hFF;
        for (int k = 0; k < 9; k++)
            for (int c = 0; c < 4; c++) begin
                step();
                chk($sformatf("rr_k%0d_c%0d", k, c), gnt4, 8'd1 << (k % 8));
            end
        chk("rr_nohold_stays", gnt0, 8'h01);
        // pointer wrap from 7 to 0
        req = 8'h00;
        step();
        req = 8'h40;
        step();
        chk("wrap_g6", gnt4, 8'h40);
        req = 8'h00;
        step();
        req = 8'h41;
        step();
        chk("wrap_win0", gnt4, 8'h01);
        chk("wrap_win0_nh", gnt0, 8'h01);
        req = 8'h00;
        step();
        req = 8'h41;
        step();
        chk("ptr1_win6", gnt4, 8'h40);
        // lone requester holds, then preempted
        req   = 8'h00;
        rr_en = 0;
        step();
        req = 8'h08;
        for (int c = 0; c < 20; c++) begin
            step();
            chk($sformatf("lone_c%0d", c), gnt4, 8'h08);
        end
        req = 8'h28;
        step();
        chk("preempt_gnt", gnt4, 8'h20);
        chk("preempt_id", id4, 5);
        chk("nohold_keeps", gnt0, 8'h08);
        // reset mid-grant
        req   = 8'h00;
        rr_en = 1;
        step();
        req = 8'h10;
        step();
        chk("mid_g4", gnt4, 8'h10);
        req = 8'h30;
        rst = 1;
        step();
        chk("mid_rst_gnt", gnt4, 0);
        chk("mid_rst_valid", v4, 0);
        rst = 0;
        step();
        chk("post_rst_g4", gnt4, 8'h10);
        req = 8'h00;
        step();
        req = 8'h21;
        step();
        chk("post_rst_ptr5", gnt4, 8'h20);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
